// File: rtl/dmem_ctrl.sv
// Data-SRAM sequencer: arbitrates the MEM-stage load/store port and an aux word port onto one
// single-port word SRAM, with read-modify-write for sub-word stores and load extraction/extension.
module dmem_ctrl #(
    parameter int unsigned AW         = 30,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_core_req,
    input  logic          i_core_we,
    input  logic [2:0]    i_core_funct3,
    input  logic [31:0]   i_core_addr,
    input  logic [31:0]   i_core_wdata,
    output logic          o_core_stall,
    output logic          o_core_rvalid,
    output logic [31:0]   o_core_rdata,
    output logic          o_core_err,
    input  logic          i_aux_req,
    input  logic          i_aux_we,
    input  logic [31:0]   i_aux_addr,
    input  logic [31:0]   i_aux_wdata,
    output logic          o_aux_gnt,
    output logic          o_aux_rvalid,
    output logic [31:0]   o_aux_rdata,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [31:0]   o_mem_wdata,
    input  logic [31:0]   i_mem_rdata
);

    localparam int unsigned CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        CORE_RD,
        RMW_RD,
        RMW_WR,
        AUX_RD
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic [31:0]   rmw_word_q;

    logic          core_illegal;
    logic          word_store;
    logic          sub_store;
    logic          aux_win;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_data;
    logic [31:0]   merged;

    logic          stall_c, rvalid_c, err_c, gnt_c, aux_rvalid_c, mem_en_c, mem_we_c;
    logic [31:0]   rdata_c, aux_rdata_c, mem_wdata_c;
    logic [AW-1:0] mem_addr_c;

    // Address bits below word granularity are meaningless on the word-only aux port.
    logic          unused_aux_lsb;
    assign unused_aux_lsb = ^i_aux_addr[1:0];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            rmw_word_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            if (state_q == RMW_RD) begin
                rmw_word_q <= i_mem_rdata;
            end
        end
    end

    // Alignment and funct3 legality of the core request.
    always_comb begin
        core_illegal = 1'b0;
        case (i_core_funct3)
            3'b000, 3'b100: core_illegal = 1'b0;
            3'b001, 3'b101: core_illegal = i_core_addr[0];
            3'b010:         core_illegal = |i_core_addr[1:0];
            default:        core_illegal = 1'b1;
        endcase
        if (i_core_we && (i_core_funct3 > 3'b010)) begin
            core_illegal = 1'b1;
        end
    end

    assign word_store = i_core_we && (i_core_funct3 == 3'b010);
    assign sub_store  = i_core_we && (i_core_funct3[2:1] == 2'b00);
    assign aux_win    = i_aux_req && (!i_core_req || (starve_q == CW'(STARVE_MAX)));

    // Load lane extraction and extension.
    assign byte_sel = 8'(i_mem_rdata >> {i_core_addr[1:0], 3'b000});
    assign half_sel = 16'(i_mem_rdata >> {i_core_addr[1], 4'b0000});

    always_comb begin
        case (i_core_funct3)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_data = i_mem_rdata;
            3'b100:  load_data = {24'h0, byte_sel};
            3'b101:  load_data = {16'h0, half_sel};
            default: load_data = '0;
        endcase
    end

    // Sub-word store merge into the word captured during RMW_RD.
    always_comb begin
        merged = rmw_word_q;
        if (i_core_funct3[0]) begin
            merged[{i_core_addr[1], 4'b0000} +: 16] = i_core_wdata[15:0];
        end else begin
            merged[{i_core_addr[1:0], 3'b000} +: 8] = i_core_wdata[7:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        stall_c      = 1'b0;
        rvalid_c     = 1'b0;
        rdata_c      = '0;
        err_c        = 1'b0;
        gnt_c        = 1'b0;
        aux_rvalid_c = 1'b0;
        aux_rdata_c  = '0;
        mem_en_c     = 1'b0;
        mem_we_c     = 1'b0;
        mem_addr_c   = '0;
        mem_wdata_c  = '0;
        case (state_q)
            IDLE: begin
                stall_c = i_core_req;
                if (aux_win) begin
                    gnt_c      = 1'b1;
                    starve_d   = '0;
                    mem_en_c   = 1'b1;
                    mem_we_c   = i_aux_we;
                    mem_addr_c = i_aux_addr[AW+1:2];
                    if (i_aux_we) begin
                        mem_wdata_c = i_aux_wdata;
                    end else begin
                        state_d = AUX_RD;
                    end
                end else if (i_core_req) begin
                    if (i_aux_req && (starve_q < CW'(STARVE_MAX))) begin
                        starve_d = starve_q + CW'(1);
                    end
                    if (core_illegal) begin
                        err_c   = 1'b1;
                        stall_c = 1'b0;
                    end else if (word_store) begin
                        stall_c     = 1'b0;
                        mem_en_c    = 1'b1;
                        mem_we_c    = 1'b1;
                        mem_addr_c  = i_core_addr[AW+1:2];
                        mem_wdata_c = i_core_wdata;
                    end else begin
                        mem_en_c   = 1'b1;
                        mem_addr_c = i_core_addr[AW+1:2];
                        state_d    = sub_store ? RMW_RD : CORE_RD;
                    end
                end
            end
            CORE_RD: begin
                rvalid_c = 1'b1;
                rdata_c  = load_data;
                state_d  = IDLE;
            end
            RMW_RD: begin
                stall_c = i_core_req;
                state_d = RMW_WR;
            end
            RMW_WR: begin
                mem_en_c    = 1'b1;
                mem_we_c    = 1'b1;
                mem_addr_c  = i_core_addr[AW+1:2];
                mem_wdata_c = merged;
                state_d     = IDLE;
            end
            AUX_RD: begin
                aux_rvalid_c = 1'b1;
                aux_rdata_c  = i_mem_rdata;
                stall_c      = i_core_req;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset forces every output low, so an interrupted RMW_WR never reaches the SRAM.
    assign o_core_stall  = i_rst_n & stall_c;
    assign o_core_rvalid = i_rst_n & rvalid_c;
    assign o_core_rdata  = {32{i_rst_n}} & rdata_c;
    assign o_core_err    = i_rst_n & err_c;
    assign o_aux_gnt     = i_rst_n & gnt_c;
    assign o_aux_rvalid  = i_rst_n & aux_rvalid_c;
    assign o_aux_rdata   = {32{i_rst_n}} & aux_rdata_c;
    assign o_mem_en      = i_rst_n & mem_en_c;
    assign o_mem_we      = i_rst_n & mem_we_c;
    assign o_mem_addr    = {AW{i_rst_n}} & mem_addr_c;
    assign o_mem_wdata   = {32{i_rst_n}} & mem_wdata_c;

endmodule
